// File: rtl/instr_fetch_if.sv
// Instruction-memory read channel between the fetch stage and instruction memory.
// Latency: none, wires only.
// Backpressure: request side is valid/ready; the response side has no ready and is accepted by the fetch FSM only in WAIT.
interface instr_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    // Fetch stage side: issues requests, consumes responses.
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    // Memory side: accepts requests, returns read data.
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: holds the architectural PC, reads one instruction per retire, presents it to decode.
// Latency: minimum 3 cycles fetch-to-fetch (REQ, WAIT, HOLD); response captured no earlier than one edge after acceptance.
// Backpressure: REQ holds address stable until imem_req_ready; WAIT waits indefinitely; HOLD waits for pc_update.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    instr_fetch_if.master imem,
    output logic [31:0] pc,
    input  logic [31:0] pc_next,
    input  logic        pc_update,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic        misaligned,
    output logic [31:0] retire_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_q;
    logic [31:0] instr_d;
    logic [31:0] count_q;
    logic [31:0] count_d;

    // A retire is only meaningful while an instruction is held; the target
    // must be word aligned or the core stops fetching until reset.
    logic retire_ok;
    logic retire_bad;

    assign retire_ok  = pc_update && (pc_next[1:0] == 2'b00);
    assign retire_bad = pc_update && (pc_next[1:0] != 2'b00);

    // State and datapath registers; reset takes effect immediately in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            count_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    // Next-state and datapath updates; every input is qualified by the state
    // that owns it so stray ready/response/retire strobes are harmless.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem.imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    instr_d = imem.imem_rsp_data;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (retire_ok) begin
                    pc_d    = pc_next;
                    count_d = count_q + 32'd1;
                    state_d = ST_REQ;
                end else if (retire_bad) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs straight from registered state.
    assign imem.imem_req_valid = (state_q == ST_REQ);
    assign imem.imem_req_addr  = pc_q;
    assign instr_valid         = (state_q == ST_HOLD);
    assign misaligned          = (state_q == ST_FAULT);
    assign pc                  = pc_q;
    assign instr               = instr_q;
    assign retire_count        = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a queue of expected instruction words.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: memory ready and response delay are varied per fetch.
module tb_instr_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_update;
    logic        instr_valid;
    logic [31:0] instr;
    logic        misaligned;
    logic [31:0] retire_count;

    instr_fetch_if imem_bus();

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (imem_bus),
        .pc           (pc),
        .pc_next      (pc_next),
        .pc_update    (pc_update),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .misaligned   (misaligned),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int hs_cnt = 0;
    logic [31:0] exp_q[$];

    // Count completed request handshakes seen by the memory.
    always @(posedge clk) begin
        if (rst_n && imem_bus.imem_req_valid && imem_bus.imem_req_ready) hs_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in REQ; leaves the DUT in HOLD holding the fetched word.
    task automatic do_fetch(input logic [31:0] addr, input int rdy_dly, input int rsp_dly,
                            input logic [31:0] data, input bit spur);
        int          hs0;
        logic [31:0] want;
        hs0 = hs_cnt;
        imem_bus.imem_req_ready = 1'b0;
        if (spur) begin
            pc_update = 1'b1;
            pc_next   = 32'h0000_0200;
        end
        for (int i = 0; i < rdy_dly; i++) begin
            check("req_valid_stall", {31'd0, imem_bus.imem_req_valid}, 32'd1);
            check("req_addr_stall", imem_bus.imem_req_addr, addr);
            tick();
        end
        check("req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd1);
        check("req_addr", imem_bus.imem_req_addr, addr);
        imem_bus.imem_req_ready = 1'b1;
        tick();
        imem_bus.imem_req_ready = 1'b0;
        check("req_valid_after_hs", {31'd0, imem_bus.imem_req_valid}, 32'd0);
        for (int i = 0; i < rsp_dly; i++) begin
            check("instr_valid_wait", {31'd0, instr_valid}, 32'd0);
            tick();
        end
        imem_bus.imem_rsp_valid = 1'b1;
        imem_bus.imem_rsp_data  = data;
        exp_q.push_back(data);
        tick();
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = 32'h0;
        pc_update = 1'b0;
        check("instr_valid_hold", {31'd0, instr_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            want = exp_q.pop_front();
            check("instr", instr, want);
        end
        check("pc_held", pc, addr);
        check("handshakes", hs_cnt - hs0, 32'd1);
    endtask

    // Starts in HOLD; aligned retire returns the DUT to REQ at the new PC.
    task automatic do_retire(input logic [31:0] nxt, input logic [31:0] exp_cnt);
        pc_update = 1'b1;
        pc_next   = nxt;
        tick();
        pc_update = 1'b0;
        check("retire_pc", pc, nxt);
        check("retire_count", retire_count, exp_cnt);
        check("retire_req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd1);
        check("retire_req_addr", imem_bus.imem_req_addr, nxt);
        check("retire_instr_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pc"}, pc, RST_PC);
        check({tag, "_req_valid"}, {31'd0, imem_bus.imem_req_valid}, 32'd0);
        check({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_misaligned"}, {31'd0, misaligned}, 32'd0);
        check({tag, "_count"}, retire_count, 32'd0);
        check({tag, "_instr"}, instr, 32'd0);
    endtask

    initial begin
        rst_n                   = 1'b0;
        pc_update               = 1'b0;
        pc_next                 = 32'h0;
        imem_bus.imem_req_ready = 1'b0;
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = 32'h0;
        repeat (3) tick();
        check_reset_vals("reset");

        // First fetch right after reset release.
        rst_n = 1'b1;
        check("idle_req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd0);
        tick();
        do_fetch(32'h0000_0100, 0, 0, 32'h0050_0093, 1'b0);

        // Stray response while holding must not touch instr.
        imem_bus.imem_rsp_valid = 1'b1;
        imem_bus.imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_bus.imem_rsp_valid = 1'b0;
        check("hold_stray_rsp_instr", instr, 32'h0050_0093);
        check("hold_stray_rsp_valid", {31'd0, instr_valid}, 32'd1);

        // Sequential retires, one with backpressure, slow memory and stray pc_update.
        do_retire(32'h0000_0104, 32'd1);
        do_fetch(32'h0000_0104, 4, 6, 32'h00A0_0113, 1'b1);
        do_retire(32'h0000_0108, 32'd2);
        do_fetch(32'h0000_0108, 0, 0, 32'h0020_81B3, 1'b0);
        do_retire(32'h0000_010C, 32'd3);
        do_fetch(32'h0000_010C, 1, 2, 32'h4020_8233, 1'b1);
        do_retire(32'h0000_0110, 32'd4);
        do_fetch(32'h0000_0110, 0, 0, 32'h0000_0013, 1'b0);

        // Jump target.
        do_retire(32'h0000_2000, 32'd5);
        do_fetch(32'h0000_2000, 0, 1, 32'h0000_006F, 1'b0);

        // Misaligned target faults and stops fetching.
        pc_update = 1'b1;
        pc_next   = 32'h0000_2006;
        tick();
        check("fault_misaligned", {31'd0, misaligned}, 32'd1);
        check("fault_pc", pc, 32'h0000_2000);
        check("fault_count", retire_count, 32'd5);
        check("fault_instr_valid", {31'd0, instr_valid}, 32'd0);
        pc_next = 32'h0000_3000;
        imem_bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("fault_no_req", {31'd0, imem_bus.imem_req_valid}, 32'd0);
            check("fault_sticky", {31'd0, misaligned}, 32'd1);
            check("fault_pc_stable", pc, 32'h0000_2000);
        end
        pc_update = 1'b0;
        imem_bus.imem_req_ready = 1'b0;

        // Reset pulse clears the fault; fetch restarts at the reset PC.
        rst_n = 1'b0;
        #1;
        check_reset_vals("fault_reset");
        tick();
        rst_n = 1'b1;
        tick();
        do_fetch(RST_PC, 0, 0, 32'h0010_0513, 1'b0);

        // Reset asserted in WAIT, with a stale response arriving afterwards.
        do_retire(32'h0000_0104, 32'd1);
        imem_bus.imem_req_ready = 1'b1;
        tick();
        imem_bus.imem_req_ready = 1'b0;
        check("in_wait_req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("wait_reset");
        imem_bus.imem_rsp_valid = 1'b1;
        imem_bus.imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        rst_n = 1'b1;
        tick();
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = 32'h0;
        check("stale_rsp_instr", instr, 32'd0);
        check("stale_rsp_instr_valid", {31'd0, instr_valid}, 32'd0);
        do_fetch(RST_PC, 2, 3, 32'h0000_0073, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage of the single-issue RISC-V core. Holds the architectural program counter, issues one instruction-memory read per instruction over a valid/ready request channel, and captures the response. Presents the fetched word to decode until the core retires it. On retirement it loads the next PC produced by the PC-selection logic. The `pc` output is the value the PC selector consumes; `pc_next` is the selector's result returned here.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be 4-byte aligned.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc`  out  32  current architectural PC (address of the instruction being fetched or held).
- `pc_next`  in  32  next PC from the PC-selection logic; sampled only on an accepted retire.
- `pc_update`  in  1  retire strobe: the held instruction has completed, load `pc_next`.
- `imem_req_valid`  out  1  read request pending.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  32  read address; always equals `pc`.
- `imem_rsp_valid`  in  1  read data valid this cycle.
- `imem_rsp_data`  in  32  read data.
- `instr_valid`  out  1  `instr` holds a fetched instruction for `pc`.
- `instr`  out  32  fetched instruction word.
- `misaligned`  out  1  sticky fault: a retire supplied `pc_next[1:0] != 2'b00`.
- `retire_count`  out  32  number of accepted retires, wraps modulo 2^32.

## Operation
- The FSM has five states: IDLE, REQ, WAIT, HOLD, FAULT.
- Outputs are Moore, derived from registered state only:
  - `imem_req_valid` is 1 only in REQ.
  - `instr_valid` is 1 only in HOLD.
  - `misaligned` is 1 only in FAULT.
- **IDLE**: entered only by reset. Moves to REQ unconditionally on the next edge.
- **REQ**: `imem_req_valid`=1 with `imem_req_addr`=`pc`. Addr is stable while waiting. On an edge with `imem_req_ready`=1, move to WAIT; otherwise stay.
- **WAIT**: on an edge with `imem_rsp_valid`=1, register `imem_rsp_data` into `instr` and move to HOLD. Otherwise stay; latency is unbounded.
- **HOLD**: `instr` and `pc` are held stable. On an edge with `pc_update`=1:
  - If `pc_next[1:0]==2'b00`: `pc` <= `pc_next`, `retire_count` += 1, move to REQ.
  - Otherwise: `pc` stays unchanged, `retire_count` stays unchanged, move to FAULT.
- **FAULT**: terminal. No requests are issued. Only `rst_n` leaves this state.
- Ignored inputs:
  - `pc_update` is ignored outside HOLD.
  - `imem_rsp_valid` is ignored outside WAIT, so a stray response never corrupts `instr`.
  - `imem_req_ready` is ignored outside REQ.
- `pc_next` is taken verbatim. No arithmetic is done here; +4, jump and branch selection are upstream.
- `instr` keeps its last captured value outside HOLD. Its value is meaningful only when `instr_valid`=1.

## Timing
- Reset (asynchronous assert, synchronous effect on release):
  - state=IDLE, `pc`=RESET_PC, `instr`=0, `retire_count`=0.
  - `imem_req_valid`=0, `instr_valid`=0, `misaligned`=0.
- First request: `imem_req_valid` rises after the first rising edge following `rst_n` deassertion.
- Request acceptance: if the handshake (`valid`&`ready`) completes at edge k, then `imem_req_valid`=0 from k.
- Response: the earliest one that can be captured is at edge k+1. A response in the same cycle as acceptance is not captured.
- Delivery: if response is captured at edge m, then `instr_valid`=1 from m. If retire occurs at edge h, then `instr_valid`=0 and `imem_req_valid`=1 with the new `pc` from h.
- Minimum fetch-to-fetch period: 3 cycles (REQ, WAIT, HOLD), with ready=1, response one cycle after acceptance, and immediate retire.
- Reset asserted mid-operation (any state, including FAULT): all registers take reset values immediately. An outstanding memory response after reset is ignored until the next WAIT.
- `retire_count` wraps from 32'hFFFF_FFFF to 0 with no flag.

## Test plan
- **Reset/first fetch**: RESET_PC=32'h0000_0100; release `rst_n` with ready=1, response one cycle later with data 32'h0050_0093 -> `imem_req_addr`=0x100 for exactly one cycle, then `instr_valid`=1 and `instr`=0x0050_0093.
- **Backpressure and slow memory**: hold `imem_req_ready`=0 for 4 cycles, then delay response 6 cycles -> addr stable throughout REQ, exactly one handshake, `instr_valid` rises on the response edge only.
- **Sequential retire**: in HOLD at pc=0x100, drive `pc_update`=1 with `pc_next`=0x104 -> `pc`=0x104, `retire_count`=1, new request to 0x104 the next cycle. Repeat 3 times -> count=4.
- **Jump target**: retire with `pc_next`=0x0000_2000 -> next request address is 0x2000.
- **Misaligned target**: retire with `pc_next`=0x0000_0106 -> `misaligned`=1, `pc` stays 0x104, no further `imem_req_valid` for 20 cycles. Then pulse `rst_n` -> fault cleared, fetch restarts at RESET_PC.
- **Spurious inputs**:
  - `pc_update` asserted during REQ/WAIT -> no PC change.
  - `imem_rsp_valid` with 32'hDEAD_BEEF during HOLD -> `instr` unchanged.
  - Reset asserted in WAIT -> all outputs at reset values on that cycle.
